// File: rtl/bmac_pkg.sv
// Shared helpers for the binary MAC datapath: popcount width, contribution
// sign-extension and saturating addition.
package bmac_pkg;

    typedef struct packed {
        logic signed [63:0] sum;
        logic               clamp;
    } sat_res_t;

    function automatic int pc_width(input int n);
        return $clog2(n + 1);
    endfunction

    // Dot-product contribution of one beat: matches minus mismatches.
    function automatic logic signed [63:0] contrib(input int pc, input int n);
        return 64'(2 * pc - n);
    endfunction

    function automatic sat_res_t sat_add(input logic signed [63:0] a,
                                         input logic signed [63:0] b,
                                         input int                 w);
        logic signed [63:0] hi, lo, s;
        sat_res_t           r;
        hi      = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo      = -hi - 64'sd1;
        s       = a + b;
        r.clamp = (s > hi) || (s < lo);
        r.sum   = (s > hi) ? hi : ((s < lo) ? lo : s);
        return r;
    endfunction

endpackage

// File: rtl/xnor_popcount_mac_if.sv
// Beat input and frame-result output of the XNOR/popcount MAC.
interface xnor_popcount_mac_if #(
    parameter int IN_WIDTH  = 32,
    parameter int ACC_WIDTH = 16,
    parameter int CNT_WIDTH = 16
);
    logic                        in_valid;
    logic                        in_ready;
    logic [IN_WIDTH-1:0]         in_0;
    logic [IN_WIDTH-1:0]         in_1;
    logic                        in_last;
    logic                        out_valid;
    logic                        out_ready;
    logic signed [ACC_WIDTH-1:0] out_sum;
    logic [CNT_WIDTH-1:0]        out_count;
    logic                        out_sat;

    modport master (
        output in_valid, in_0, in_1, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_count, out_sat
    );

    modport slave (
        input  in_valid, in_0, in_1, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_count, out_sat
    );
endinterface

// File: rtl/xnor_popcount_mac_popcount_tree.sv
// Combinational balanced adder tree counting the ones in x.
module popcount_tree
    import bmac_pkg::*;
#(
    parameter int IN_WIDTH = 32,
    localparam int PCW     = pc_width(IN_WIDTH)
) (
    input  logic [IN_WIDTH-1:0] x,
    output logic [PCW-1:0]      pc
);
    localparam int L = $clog2(IN_WIDTH);
    localparam int P = 1 << L;

    logic [P-1:0] xp;
    assign xp = P'(x);

    // One generate level per tree depth, leaves padded with zeros to a power of two.
    genvar l, i;
    generate
        for (l = 0; l <= L; l++) begin : lvl
            logic [PCW-1:0] s [P >> l];
            for (i = 0; i < (P >> l); i++) begin : nd
                if (l == 0) begin : leaf
                    assign s[i] = PCW'(xp[i]);
                end else begin : add
                    assign s[i] = lvl[l-1].s[2*i] + lvl[l-1].s[2*i+1];
                end
            end
        end
    endgenerate

    assign pc = lvl[L].s[0];
endmodule

// File: rtl/xnor_popcount_mac.sv
// Three-stage binary MAC: XNOR, popcount/contribution, frame accumulate.
// Define XNOR_MAC_SAT_EN for saturating accumulation with a sticky out_sat.
module xnor_popcount_mac
    import bmac_pkg::*;
#(
    parameter int IN_WIDTH  = 32,
    parameter int ACC_WIDTH = 16,
    parameter int CNT_WIDTH = 16
) (
    input logic               clk,
    input logic               rst_n,
    xnor_popcount_mac_if.slave bus
);
    localparam int PCW    = pc_width(IN_WIDTH);
    localparam int STAGES = 2;

    logic                        adv;
    logic [STAGES:1]             vld_pipe;
    logic [STAGES:1]             last_pipe;
    logic [IN_WIDTH-1:0]         s1_x;
    logic [PCW-1:0]              pc;
    logic signed [ACC_WIDTH-1:0] s2_c;
    logic signed [ACC_WIDTH-1:0] acc, acc_nxt;
    logic [CNT_WIDTH-1:0]        cnt, cnt_nxt;
    logic                        frame_start;
    logic                        beat, out_load;

    // Whole pipeline freezes while a result is held and not taken.
    assign adv          = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = adv;
    assign beat         = adv && vld_pipe[STAGES];
    assign out_load     = beat && last_pipe[STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe  <= '0;
            last_pipe <= '0;
        end else if (adv) begin
            vld_pipe  <= {vld_pipe[STAGES-1:1], bus.in_valid};
            last_pipe <= {last_pipe[STAGES-1:1], bus.in_last};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_x <= '0;
            s2_c <= '0;
        end else if (adv) begin
            s1_x <= ~(bus.in_0 ^ bus.in_1);
            s2_c <= ACC_WIDTH'(contrib(int'(pc), IN_WIDTH));
        end
    end

    popcount_tree #(.IN_WIDTH(IN_WIDTH)) u_popcount (
        .x  (s1_x),
        .pc (pc)
    );

    assign cnt_nxt = frame_start ? CNT_WIDTH'(1) : cnt + CNT_WIDTH'(1);

`ifdef XNOR_MAC_SAT_EN
    sat_res_t sat_res;
    logic     sat_flag, sat_nxt;

    always_comb begin
        sat_res = sat_add(64'(acc), 64'(s2_c), ACC_WIDTH);
        sat_nxt = !frame_start && (sat_flag || sat_res.clamp);
        acc_nxt = frame_start ? s2_c : ACC_WIDTH'(sat_res.sum);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_flag    <= 1'b0;
            bus.out_sat <= 1'b0;
        end else begin
            if (beat)     sat_flag    <= sat_nxt;
            if (out_load) bus.out_sat <= sat_nxt;
        end
    end
`else
    assign acc_nxt     = frame_start ? s2_c : acc + s2_c;
    assign bus.out_sat = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc         <= '0;
            cnt         <= '0;
            frame_start <= 1'b1;
        end else if (beat) begin
            acc         <= acc_nxt;
            cnt         <= cnt_nxt;
            frame_start <= last_pipe[STAGES];
        end
    end

    // Result registers are separate from acc so the next frame can run on.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid <= 1'b0;
            bus.out_sum   <= '0;
            bus.out_count <= '0;
        end else if (adv) begin
            bus.out_valid <= vld_pipe[STAGES] && last_pipe[STAGES];
            if (out_load) begin
                bus.out_sum   <= acc_nxt;
                bus.out_count <= cnt_nxt;
            end
        end
    end
endmodule

// File: tb/tb_xnor_popcount_mac.sv
// Scoreboard bench for xnor_popcount_mac with IN_WIDTH=8, ACC_WIDTH=6.
module tb_xnor_popcount_mac;
    localparam int IW = 8;
    localparam int AW = 6;
    localparam int CW = 16;

    typedef struct {
        logic signed [AW-1:0] sum;
        logic [CW-1:0]        count;
        logic                 sat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    xnor_popcount_mac_if #(.IN_WIDTH(IW), .ACC_WIDTH(AW), .CNT_WIDTH(CW)) bus ();

    xnor_popcount_mac #(.IN_WIDTH(IW), .ACC_WIDTH(AW), .CNT_WIDTH(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic expect_frame(input int s, input int c, input logic sat);
        exp_t e;
        e.sum   = AW'(s);
        e.count = CW'(c);
        e.sat   = sat;
        sb.push_back(e);
    endtask

    // Drive at a falling edge; returns on the falling edge after acceptance.
    task automatic send(input logic [IW-1:0] a, input logic [IW-1:0] b, input logic last);
        int n;
        bus.in_valid = 1'b1;
        bus.in_0     = a;
        bus.in_1     = b;
        bus.in_last  = last;
        n = 0;
        #1;
        while (!bus.in_ready && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!bus.in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready stayed %0d, expected 1", bus.in_ready);
        end
        @(negedge clk);
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check("drain_pending", sb.size(), 0);
    endtask

    // Monitor: pop and compare on every output handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (rst_n && bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got sum %0d, expected no result", bus.out_sum);
                end else begin
                    e = sb.pop_front();
                    check("out_sum", bus.out_sum, e.sum);
                    check("out_count", bus.out_count, e.count);
                    check("out_sat", bus.out_sat, e.sat);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_0      = '0;
        bus.in_1      = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_sum", bus.out_sum, 0);
        check("rst_out_count", bus.out_count, 0);
        check("rst_out_sat", bus.out_sat, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // +8 single-beat frame, checking latency edge by edge
        expect_frame(8, 1, 1'b0);
        send(8'hFF, 8'hFF, 1'b1);
        idle();
        #1 check("lat_edge_t", bus.out_valid, 0);
        @(negedge clk);
        #1 check("lat_edge_t1", bus.out_valid, 0);
        @(negedge clk);
        #1 check("lat_edge_t2", bus.out_valid, 1);
        @(negedge clk);

        expect_frame(-8, 1, 1'b0);
        send(8'hFF, 8'h00, 1'b1);
        idle();

        // +8, -8, 0 back-to-back
        expect_frame(0, 3, 1'b0);
        send(8'hA5, 8'hA5, 1'b0);
        send(8'hA5, 8'h5A, 1'b0);
        send(8'hF0, 8'hFF, 1'b1);
        idle();

        // 5 x +8 = 40 exceeds the 6-bit range
`ifdef XNOR_MAC_SAT_EN
        expect_frame(31, 5, 1'b1);
`else
        expect_frame(-24, 5, 1'b0);
`endif
        repeat (4) send(8'hFF, 8'hFF, 1'b0);
        send(8'hFF, 8'hFF, 1'b1);
        idle();
        wait_drain();

        // Back-pressure: two results, consumer stalled for 4 cycles
        bus.out_ready = 1'b0;
        expect_frame(8, 1, 1'b0);
        expect_frame(-8, 1, 1'b0);
        send(8'hFF, 8'hFF, 1'b1);
        send(8'hFF, 8'h00, 1'b1);
        idle();
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            #1;
            check("stall_in_ready", bus.in_ready, 0);
            check("stall_out_valid", bus.out_valid, 1);
            check("stall_out_sum", bus.out_sum, 8);
            check("stall_out_count", bus.out_count, 1);
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        wait_drain();

        // Reset in the middle of a frame discards the partial sum
        send(8'hFF, 8'hFF, 1'b0);
        send(8'h00, 8'hFF, 1'b0);
        idle();
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", bus.out_valid, 0);
        check("mid_rst_out_sum", bus.out_sum, 0);
        check("mid_rst_out_count", bus.out_count, 0);
        check("mid_rst_in_ready", bus.in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        expect_frame(8, 1, 1'b0);
        send(8'hFF, 8'hFF, 1'b1);
        idle();
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
